// File: rtl/fifo_block_writer_if.sv
// Bus bundle between an upstream block producer, the block writer and a FIFO write port.
// The instance parameters must match the DSIZE/WORDS of the writer it connects to.
interface fifo_block_writer_if #(
  parameter int DSIZE = 32,
  parameter int WORDS = 4
);
  localparam int BW = DSIZE * WORDS;

  logic             in_valid;
  logic             in_ready;
  logic [BW-1:0]    in_data;
  logic [DSIZE-1:0] wdata;
  logic             winc;
  logic             wfull;

  // master: the environment (block source and FIFO); slave: the block writer
  modport master (
    output in_valid,
    output in_data,
    output wfull,
    input  in_ready,
    input  wdata,
    input  winc
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  wfull,
    output in_ready,
    output wdata,
    output winc
  );
endinterface

// File: rtl/fifo_block_writer.sv
// Splits a wide block into DSIZE-bit words (most significant word first) and
// pushes them into a FIFO write port, stalling while the FIFO reports full.
module fifo_block_writer #(
  parameter int DSIZE = 32,
  parameter int WORDS = 4,
  parameter int CW    = 16
) (
  input  logic                wclk,
  input  logic                dirclr_n,
  fifo_block_writer_if.slave  bus,
  output logic                busy,
  output logic [CW-1:0]       blk_count,
  output logic [CW-1:0]       stall_count
);
  localparam int BW = DSIZE * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t          r_state;
  logic            r_busy;
  logic            r_out_en;
  logic [IW-1:0]   r_idx;
  logic [BW-1:0]   r_blk;
  logic [CW-1:0]   r_blk_count;
  logic [CW-1:0]   r_stall_count;

  logic [DSIZE-1:0] w_word [WORDS];
  logic             w_winc;
  logic             w_last;
  logic             w_in_ready;
  logic             w_accept;

  generate
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
      assign w_word[gi] = r_blk[BW-1-gi*DSIZE -: DSIZE];
    end
  endgenerate

  // wfull gates the strobe combinationally so a word is never offered into a full FIFO
  assign w_winc     = r_busy & ~bus.wfull;
  assign w_last     = w_winc & (r_idx == LAST_IDX);
  // r_out_en keeps in_ready low during reset and until the first edge after release
  assign w_in_ready = r_out_en & (~r_busy | w_last);
  assign w_accept   = bus.in_valid & w_in_ready;

  assign bus.winc     = w_winc;
  assign bus.in_ready = w_in_ready;
  assign bus.wdata    = w_word[r_idx];
  assign busy         = r_busy;
  assign blk_count    = r_blk_count;
  assign stall_count  = r_stall_count;

  always_ff @(posedge wclk or negedge dirclr_n) begin
    if (!dirclr_n) begin
      r_state       <= S_IDLE;
      r_busy        <= 1'b0;
      r_out_en      <= 1'b0;
      r_idx         <= '0;
      r_blk         <= '0;
      r_blk_count   <= '0;
      r_stall_count <= '0;
    end else begin
      r_out_en <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_blk   <= bus.in_data;
            r_idx   <= '0;
            r_state <= S_SEND;
            r_busy  <= 1'b1;
          end
        end
        S_SEND: begin
          if (bus.wfull) begin
            if (r_stall_count != {CW{1'b1}})
              r_stall_count <= r_stall_count + CW'(1);
          end else if (r_idx == LAST_IDX) begin
            r_blk_count <= r_blk_count + CW'(1);
            // zero-bubble handoff: a waiting block is captured on the last write
            if (bus.in_valid) begin
              r_blk <= bus.in_data;
              r_idx <= '0;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_block_writer.sv
// Directed bench for fifo_block_writer; a second CW=4 instance shares the inputs
// so the block counter wrap can be observed alongside the main instance.
module tb_fifo_block_writer;
  localparam int DSIZE = 32;
  localparam int WORDS = 4;

  logic wclk = 1'b0;
  logic dirclr_n;
  always #5 wclk = ~wclk;

  fifo_block_writer_if #(.DSIZE(DSIZE), .WORDS(WORDS)) bus ();
  fifo_block_writer_if #(.DSIZE(DSIZE), .WORDS(WORDS)) bus4 ();

  assign bus4.in_valid = bus.in_valid;
  assign bus4.in_data  = bus.in_data;
  assign bus4.wfull    = bus.wfull;

  logic        busy, busy4;
  logic [15:0] blk_count, stall_count;
  logic [3:0]  blk4, stall4;

  fifo_block_writer #(.DSIZE(DSIZE), .WORDS(WORDS), .CW(16)) dut (
    .wclk        (wclk),
    .dirclr_n    (dirclr_n),
    .bus         (bus.slave),
    .busy        (busy),
    .blk_count   (blk_count),
    .stall_count (stall_count)
  );

  fifo_block_writer #(.DSIZE(DSIZE), .WORDS(WORDS), .CW(4)) dut4 (
    .wclk        (wclk),
    .dirclr_n    (dirclr_n),
    .bus         (bus4.slave),
    .busy        (busy4),
    .blk_count   (blk4),
    .stall_count (stall4)
  );

  int tests  = 0;
  int fails  = 0;
  int wr_cnt = 0;
  int w0;

  // Count FIFO writes mid-cycle, where winc and wfull are stable
  always @(negedge wclk) if (bus.winc === 1'b1) wr_cnt++;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  function automatic logic [127:0] mk(input int b);
    logic [127:0] r;
    for (int w = 0; w < 4; w++) r[127-32*w -: 32] = 32'hC0DE0000 + 32'(b * 16 + w);
    return r;
  endfunction

  function automatic logic [31:0] wd(input logic [127:0] blk, input int i);
    return blk[127-32*i -: 32];
  endfunction

  // Sends n blocks back-to-back starting from IDLE, checking every word cycle
  task automatic run_b2b(input int n, input int b0);
    bus.in_valid = 1'b1;
    bus.in_data  = mk(b0);
    #1 check("b2b_accept_ready", bus.in_ready, 1);
    tick();
    for (int b = 0; b < n; b++) begin
      bus.in_valid = (b < n - 1);
      bus.in_data  = mk(b0 + b + 1);
      for (int w = 0; w < 4; w++) begin
        #1;
        check("b2b_winc", bus.winc, 1);
        check("b2b_wdata", bus.wdata, wd(mk(b0 + b), w));
        check("b2b_in_ready", bus.in_ready, (w == 3) ? 1 : 0);
        tick();
      end
    end
    check("b2b_idle_busy", busy, 0);
  endtask

  logic [127:0] k1, k2, k3, k4, k5;

  initial begin
    k1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    k2 = mk(100);
    k3 = mk(200);
    k4 = mk(201);
    k5 = mk(300);

    dirclr_n     = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.wfull    = 1'b0;

    // Reset state
    #2;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_winc", bus.winc, 0);
    check("rst_busy", busy, 0);
    check("rst_wdata", bus.wdata, 0);
    check("rst_blk_count", blk_count, 0);
    check("rst_stall_count", stall_count, 0);
    tick();
    tick();
    check("rst_held_in_ready", bus.in_ready, 0);
    #4 dirclr_n = 1'b1;
    #1 check("rst_release_in_ready", bus.in_ready, 0);
    tick();
    check("post_rst_in_ready", bus.in_ready, 1);
    check("post_rst_winc", bus.winc, 0);

    // Single block
    w0 = wr_cnt;
    bus.in_valid = 1'b1;
    bus.in_data  = k1;
    #1 check("single_accept", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    for (int w = 0; w < 4; w++) begin
      #1;
      check("single_winc", bus.winc, 1);
      check("single_busy", busy, 1);
      check("single_wdata", bus.wdata, wd(k1, w));
      tick();
    end
    check("single_done_busy", busy, 0);
    check("single_done_winc", bus.winc, 0);
    check("single_blk_count", blk_count, 1);
    check("single_idle_ready", bus.in_ready, 1);
    check("single_writes", wr_cnt - w0, 4);

    // Three blocks back-to-back
    run_b2b(3, 0);
    check("b2b_blk_count", blk_count, 4);
    check("b2b_stall_count", stall_count, 0);

    // Backpressure at word 2 for 5 cycles
    w0 = wr_cnt;
    bus.in_valid = 1'b1;
    bus.in_data  = k2;
    tick();
    bus.in_valid = 1'b0;
    for (int w = 0; w < 2; w++) begin
      #1 check("bp_wdata_pre", bus.wdata, wd(k2, w));
      tick();
    end
    bus.wfull = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_stall_winc", bus.winc, 0);
      check("bp_stall_wdata", bus.wdata, wd(k2, 2));
      check("bp_stall_busy", busy, 1);
      tick();
    end
    bus.wfull = 1'b0;
    for (int w = 2; w < 4; w++) begin
      #1;
      check("bp_resume_winc", bus.winc, 1);
      check("bp_resume_wdata", bus.wdata, wd(k2, w));
      tick();
    end
    check("bp_stall_count", stall_count, 5);
    check("bp_blk_count", blk_count, 5);
    check("bp_writes", wr_cnt - w0, 4);

    // FIFO full on the last word while a new block waits
    bus.in_valid = 1'b1;
    bus.in_data  = k3;
    tick();
    bus.in_valid = 1'b0;
    for (int w = 0; w < 3; w++) begin
      #1 check("lastfull_wdata_pre", bus.wdata, wd(k3, w));
      tick();
    end
    bus.wfull    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = k4;
    #1;
    check("lastfull_in_ready", bus.in_ready, 0);
    check("lastfull_winc", bus.winc, 0);
    tick();
    check("lastfull_busy", busy, 1);
    check("lastfull_blk_hold", blk_count, 5);
    bus.wfull = 1'b0;
    #1;
    check("lastfull_ready_release", bus.in_ready, 1);
    check("lastfull_winc_release", bus.winc, 1);
    check("lastfull_wdata_w3", bus.wdata, wd(k3, 3));
    tick();
    bus.in_valid = 1'b0;
    for (int w = 0; w < 4; w++) begin
      #1 check("lastfull_next_wdata", bus.wdata, wd(k4, w));
      check("lastfull_next_winc", bus.winc, 1);
      tick();
    end
    check("lastfull_blk_count", blk_count, 7);
    check("lastfull_stall_count", stall_count, 6);

    // Reset pulsed mid-block after two words
    bus.in_valid = 1'b1;
    bus.in_data  = k5;
    tick();
    bus.in_valid = 1'b0;
    w0 = wr_cnt;
    tick();
    tick();
    #1 dirclr_n = 1'b0;
    #1;
    check("midrst_winc", bus.winc, 0);
    check("midrst_busy", busy, 0);
    check("midrst_blk_count", blk_count, 0);
    check("midrst_stall_count", stall_count, 0);
    check("midrst_wdata", bus.wdata, 0);
    check("midrst_in_ready", bus.in_ready, 0);
    dirclr_n = 1'b1;
    #1 check("midrst_release_ready", bus.in_ready, 0);
    tick();
    check("midrst_writes", wr_cnt - w0, 2);
    check("midrst_ready_after_edge", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_data  = k5;
    tick();
    bus.in_valid = 1'b0;
    for (int w = 0; w < 4; w++) begin
      #1 check("midrst_restart_wdata", bus.wdata, wd(k5, w));
      tick();
    end
    check("midrst_blk_count_after", blk_count, 1);

    // Sixteen more blocks: 17 since reset, CW=4 counter wraps to 1
    run_b2b(16, 400);
    check("wrap_blk_count16", blk_count, 17);
    check("wrap_blk_count4", blk4, 1);
    check("wrap_stall4", stall4, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fifo_block_writer.md
FIFO_BLOCK_WRITER -- requirements
Module: fifo_block_writer

Interface
REQ-001 SHALL have parameter DSIZE, default 32, FIFO write word width in bits.
REQ-002 SHALL have parameter WORDS, default 4, FIFO words per block; block width BW = DSIZE*WORDS (128 default).
REQ-003 SHALL have parameter CW, default 16, width of the block and stall counters.
REQ-004 SHALL have port wclk  input  1  write-domain clock; all state updates on its rising edge.
REQ-005 SHALL have port dirclr_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  upstream block valid.
REQ-007 SHALL have port in_ready  output  1  block accepted when in_valid and in_ready are both high at a wclk rising edge.
REQ-008 SHALL have port in_data  input  BW  upstream block (e.g. AES ciphertext).
REQ-009 SHALL have port wdata  output  DSIZE  word driven to the FIFO write port.
REQ-010 SHALL have port winc  output  1  FIFO write strobe; a word is written at each wclk rising edge where winc is high.
REQ-011 SHALL have port wfull  input  1  FIFO full flag from the write domain; may assert asynchronously to wclk.
REQ-012 SHALL have port busy  output  1  high while a captured block is not fully written.
REQ-013 SHALL have port blk_count  output  CW  number of blocks fully written since reset.
REQ-014 SHALL have port stall_count  output  CW  number of cycles spent in SEND with wfull high.

Function
REQ-015 SHALL implement a two-state FSM: IDLE and SEND.
REQ-016 IDLE: in_ready SHALL be 1, winc SHALL be 0, and busy SHALL be 0.
REQ-017 IDLE to SEND: on in_valid&in_ready, SHALL register in_data into a BW-bit block register, clear word index idx to 0, and enter SEND on the next cycle.
REQ-018 SEND: busy SHALL be 1 and wdata SHALL equal block word idx, with word 0 = in_data[BW-1:BW-DSIZE] (MSW first).
REQ-019 SEND: winc SHALL be busy & ~wfull (combinational from wfull), so a word is never offered while the FIFO is full.
REQ-020 SEND with winc=1 and idx<WORDS-1: idx SHALL increment by 1.
REQ-021 SEND with wfull=1: idx, the block register and wdata SHALL hold, and stall_count SHALL increment, saturating at 2^CW-1.
REQ-022 Last word: in SEND with idx=WORDS-1 and winc=1, blk_count SHALL increment, wrapping modulo 2^CW.
REQ-023 in_ready in SEND SHALL be 1 only when idx=WORDS-1 and winc=1 (zero-bubble handoff).
REQ-024 Handoff accept: if in_valid is also high in the REQ-023 cycle, SHALL capture the new block, set idx=0 and stay in SEND.
REQ-025 Handoff no accept: if in_valid is low in the REQ-023 cycle, SHALL return to IDLE.
REQ-026 Throughput: sustained rate SHALL be one block per WORDS cycles with wfull low; latency from acceptance to first winc SHALL be 1 cycle.
REQ-027 in_data SHALL be ignored except in the acceptance cycle; in_valid deasserting without acceptance SHALL have no effect.
REQ-028 wfull asserting in the same cycle as the last word SHALL suppress that write; last-word completion SHALL occur only on a later cycle with wfull=0.

Reset
REQ-029 dirclr_n low SHALL immediately force: state=IDLE, idx=0, block register=0, blk_count=0, stall_count=0.
REQ-030 During dirclr_n low, outputs SHALL be: winc=0, busy=0, wdata=0, in_ready=0.
REQ-031 in_ready SHALL rise only after the first wclk edge following dirclr_n deassertion.
REQ-032 Reset asserted mid-block (SEND) SHALL discard the partial block without further winc; words already written stay in the FIFO; blk_count is not incremented.

Verification
REQ-033 Single block: in_data=0x00112233_44556677_8899AABB_CCDDEEFF, wfull=0 -> winc high for exactly 4 consecutive cycles starting 1 cycle after acceptance, wdata=00112233,44556677,8899AABB,CCDDEEFF in order; blk_count=1; then IDLE.
REQ-034 Back-to-back: 3 blocks with in_valid held high -> 12 consecutive winc cycles with no bubble; blk_count=3; stall_count=0.
REQ-035 Backpressure: wfull high for 5 cycles starting at word 2 -> winc=0 and wdata held at word 2 for those 5 cycles, then words 2,3 written; stall_count=5; no word lost or duplicated.
REQ-036 Full on last word: wfull high in the cycle of word 3 -> in_ready=0 that cycle, new block not accepted until word 3 is written.
REQ-037 Reset mid-block: dirclr_n pulsed low after word 1 -> winc=0 immediately, blk_count=0, busy=0; the next block starts at word 0.
REQ-038 Counter wrap: with CW=4, 17 blocks -> blk_count=1.
